fp_divider_sequential: RTL and testbench

Iterative single-precision (IEEE-754 binary32) floating-point divider. It is the inverse-operation companion to the team's sequential floating-point multiplier and uses the same operand format, zero detection and overflow-flag conventions. A restoring mantissa divider produces one quotient bit per clock, under a four-state FSM with valid/ready handshakes on both input and output. It sits in the arithmetic datapath next to the multiplier and serves consumers that can tolerate a 28-cycle latency in exchange for small area.

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_div_step.sv | 20 ++
 rtl/fp_divider_sequential.sv | 156 +++++++++++++++
 tb/tb_fp_divider_sequential.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the sequential multiplier and divider:
// binary32 field widths, the bias, special encodings and the divider FSM states.
package fp_pkg;

   localparam int FP_EXP_W  = 8;
   localparam int FP_MANT_W = 23;
   localparam int FP_BIAS   = 127;

   localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;
   localparam logic [31:0]         FP_QNAN    = 32'h7FC00000;

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      NORM,
      DONE
   } fp_div_state_t;

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division iteration: compare the partial remainder with the
// divisor mantissa, subtract when it fits, emit the quotient bit and shift.
module fp_div_step (
   input  logic [25:0] rem,
   input  logic [23:0] divisor,
   output logic [25:0] rem_next,
   output logic        q_bit
);

   logic [25:0] diff;

   // Trial subtraction; the remainder stays below twice the divisor, so the
   // shifted result always fits in 26 bits.
   always_comb begin
      q_bit    = (rem >= {2'b00, divisor});
      diff     = q_bit ? (rem - {2'b00, divisor}) : rem;
      rem_next = diff << 1;
   end

endmodule

// File: rtl/fp_divider_sequential.sv
// Iterative binary32 divider: one quotient bit per clock, valid/ready on both
// sides. Define FP_DIV_ROUND_EN to round half-up on the guard bit; otherwise
// the quotient mantissa is truncated.
module fp_divider_sequential
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] result,
   output logic        overflow,
   output logic        underflow,
   output logic        div_by_zero,
   output logic        out_valid,
   input  logic        out_ready
);

   fp_div_state_t state, state_next;

   logic [4:0]         cnt;
   logic [25:0]        rem;
   logic [25:0]        rem_next;
   logic [23:0]        div_mant;
   logic [25:0]        q;
   logic               q_bit;
   logic               sign;
   logic signed [9:0]  exp_acc;
   logic signed [9:0]  exp_start;
   logic               a_zero;
   logic               b_zero;

   logic [22:0]        mant;
   logic signed [9:0]  exp_norm;
   logic [31:0]        norm_result;
   logic               norm_ovf;
   logic               norm_unf;
`ifdef FP_DIV_ROUND_EN
   logic               guard;
   logic               carry;
   logic [22:0]        mant_rounded;
`endif

   assign a_zero    = (a == 32'h0);
   assign b_zero    = (b == 32'h0);
   assign exp_start = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'(FP_BIAS);

   fp_div_step u_step (
      .rem      (rem),
      .divisor  (div_mant),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic: zero operands skip the iteration and go straight to DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = (a_zero || b_zero) ? DONE : DIVIDE;
         DIVIDE:  if (cnt == 5'd0) state_next = NORM;
         NORM:    state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded straight from the state.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Normalise the quotient, optionally round, and range-check the exponent.
   always_comb begin
      exp_norm = exp_acc;
      if (q[25]) begin
         mant = q[24:2];
      end else begin
         mant     = q[23:1];
         exp_norm = exp_acc - 10'sd1;
      end
`ifdef FP_DIV_ROUND_EN
      guard                 = q[25] ? q[1] : q[0];
      {carry, mant_rounded} = {1'b0, mant} + {23'h0, guard};
      mant                  = mant_rounded;
      if (carry) exp_norm = exp_norm + 10'sd1;
`endif
      norm_ovf = (exp_norm >= 10'sd255);
      norm_unf = (exp_norm <= 10'sd0);
      if (norm_ovf)      norm_result = {sign, FP_EXP_MAX, 23'h0};
      else if (norm_unf) norm_result = {sign, 31'h0};
      else               norm_result = {sign, exp_norm[7:0], mant};
   end

   // Datapath registers: operand capture, iteration, and the held result.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= 5'd0;
         rem         <= 26'h0;
         div_mant    <= 24'h0;
         q           <= 26'h0;
         sign        <= 1'b0;
         exp_acc     <= 10'sd0;
         result      <= 32'h0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign <= a[31] ^ b[31];
                  if (b_zero) begin
                     result      <= a_zero ? FP_QNAN : {a[31] ^ b[31], FP_EXP_MAX, 23'h0};
                     div_by_zero <= 1'b1;
                     overflow    <= 1'b0;
                     underflow   <= 1'b0;
                  end else if (a_zero) begin
                     result      <= 32'h0;
                     div_by_zero <= 1'b0;
                     overflow    <= 1'b0;
                     underflow   <= 1'b0;
                  end else begin
                     cnt      <= 5'd25;
                     rem      <= {2'b01, a[22:0], 1'b0} >> 1;
                     div_mant <= {1'b1, b[22:0]};
                     q        <= 26'h0;
                     exp_acc  <= exp_start;
                  end
               end
            end
            DIVIDE: begin
               rem <= rem_next;
               q   <= {q[24:0], q_bit};
               if (cnt != 5'd0) cnt <= cnt - 5'd1;
            end
            NORM: begin
               result      <= norm_result;
               overflow    <= norm_ovf;
               underflow   <= norm_unf;
               div_by_zero <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_divider_sequential.sv
// Directed self-checking bench for fp_divider_sequential: reset, exact and
// rounded quotients, zero operands, range limits, backpressure, mid-op reset.
module tb_fp_divider_sequential;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] result;
   logic        overflow;
   logic        underflow;
   logic        div_by_zero;
   logic        out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   fp_divider_sequential dut (
      .clk         (clk),
      .rst         (rst),
      .a           (a),
      .b           (b),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .result      (result),
      .overflow    (overflow),
      .underflow   (underflow),
      .div_by_zero (div_by_zero),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Absolute time limit so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Present operands for one cycle and wait (bounded) for out_valid.
   // Called #1 after a rising edge; returns #1 after the edge where out_valid
   // is first seen, lat = number of edges since (and including) the handshake.
   task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, output int lat);
      a        = op_a;
      b        = op_b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Complete the output handshake and check that the divider is ready again.
   task automatic take_result(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_release: in_ready=%b out_valid=%b expected 1/0", tag, in_ready, out_valid);
      end
   endtask

   task automatic check_result(input string tag, input logic [31:0] exp_res,
                               input logic [2:0] exp_flags, input int lat, input int exp_lat);
      checks++;
      if (result !== exp_res) begin
         errors++;
         $display("[TB] FAIL %s_result: got %h expected %h", tag, result, exp_res);
      end
      checks++;
      if ({overflow, underflow, div_by_zero} !== exp_flags) begin
         errors++;
         $display("[TB] FAIL %s_flags: got %b expected %b (ovf,unf,dbz)", tag,
                  {overflow, underflow, div_by_zero}, exp_flags);
      end
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("[TB] FAIL %s_latency: got %0d expected %0d", tag, lat, exp_lat);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (result !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_result: got %h expected 00000000", result);
      end
      checks++;
      if ({overflow, underflow, div_by_zero} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b expected 000", {overflow, underflow, div_by_zero});
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_handshake: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_exact();
      int lat;
      run_op(32'h40C00000, 32'h40000000, lat);
      check_result("exact", 32'h40400000, 3'b000, lat, 28);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL exact_in_ready_done: got %b expected 0", in_ready);
      end
      take_result("exact");
   endtask

   task automatic test_rounding();
      int lat;
      logic [31:0] exp_third;
`ifdef FP_DIV_ROUND_EN
      exp_third = 32'h3EAAAAAB;
`else
      exp_third = 32'h3EAAAAAA;
`endif
      run_op(32'h3F800000, 32'h40400000, lat);
      check_result("third", exp_third, 3'b000, lat, 28);
      take_result("third");
   endtask

   task automatic test_div_by_zero();
      int lat;
      run_op(32'hBF800000, 32'h0, lat);
      check_result("neg_by_zero", 32'hFF800000, 3'b001, lat, 1);
      take_result("neg_by_zero");
      run_op(32'h0, 32'h0, lat);
      check_result("zero_by_zero", 32'h7FC00000, 3'b001, lat, 1);
      take_result("zero_by_zero");
      run_op(32'h0, 32'h40A00000, lat);
      check_result("zero_dividend", 32'h00000000, 3'b000, lat, 1);
      take_result("zero_dividend");
   endtask

   task automatic test_range();
      int lat;
      run_op(32'h7F000000, 32'h00800000, lat);
      check_result("overflow", 32'h7F800000, 3'b100, lat, 28);
      take_result("overflow");
      run_op(32'h00800000, 32'h7F000000, lat);
      check_result("underflow", 32'h00000000, 3'b010, lat, 28);
      take_result("underflow");
   endtask

   task automatic test_backpressure();
      int lat;
      a        = 32'hC0C00000;
      b        = 32'h40000000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      // Zero operands held on the inputs must be ignored while busy.
      a   = 32'h0;
      b   = 32'h0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      check_result("neg_six", 32'hC0400000, 3'b000, lat, 28);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (result !== 32'hC0400000 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_result[%0d]: got %h valid=%b expected C0400000 valid=1", i, result, out_valid);
         end
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready);
         end
      end
      in_valid = 1'b0;
      take_result("neg_six");
   endtask

   task automatic test_reset_mid();
      int lat;
      a        = 32'h40C00000;
      b        = 32'h40000000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
      checks++;
      if (result !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midreset_result: got %h expected 00000000", result);
      end
      run_op(32'h40C00000, 32'h40000000, lat);
      check_result("after_reset", 32'h40400000, 3'b000, lat, 28);
      take_result("after_reset");
   endtask

   initial begin
      rst       = 1'b1;
      a         = 32'h0;
      b         = 32'h0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_exact();
      test_rounding();
      test_div_by_zero();
      test_range();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
